// File: rtl/seg_display_ctrl.sv
// N-digit 7-segment controller: hex or double-dabble decimal, blanking, blink.
// Define SEG_SIGNED_EN for two's-complement decimal with a leading minus.
module seg_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_mode,
  input  logic                       blank_lz,
  input  logic [NUM_DIGITS-1:0]      blink_mask,
  output logic [NUM_DIGITS-1:0][7:0] segs_reg
);

  localparam int BW = 4 * (NUM_DIGITS + 1);
  localparam int HW = 4 * NUM_DIGITS;
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int NW = $clog2(DATA_WIDTH + 1);

  localparam logic [7:0] SEG_NONE  = 8'hFF;
  localparam logic [7:0] SEG_ERR   = 8'hB6;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_UPDATE
  } state_t;

  state_t                       state_q, state_d;
  logic [DATA_WIDTH-1:0]        data_q, data_d;
  logic                         mode_q, mode_d;
  logic                         blz_q, blz_d;
  logic [BW-1:0]                bcd_q, bcd_d;
  logic                         ovf_q, ovf_d;
  logic [NW-1:0]                bit_q, bit_d;
  logic [NUM_DIGITS-1:0][7:0]   held_q, held_d;
  logic [NUM_DIGITS-1:0][7:0]   segs_q, segs_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         phase_q, phase_d;
`ifdef SEG_SIGNED_EN
  logic                         neg_q, neg_d;
  logic [4:0]                   mpos;
`endif

  logic [BW-1:0]                adj;
  logic [HW-1:0]                hexv;
  logic [NUM_DIGITS-1:0][3:0]   digs;
  logic [4:0]                   msd;
  logic                         err;
  logic [NUM_DIGITS-1:0][7:0]   pat;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'h0: p = 8'h3F;
      4'h1: p = 8'h06;
      4'h2: p = 8'h5B;
      4'h3: p = 8'h4F;
      4'h4: p = 8'h66;
      4'h5: p = 8'h6D;
      4'h6: p = 8'h7D;
      4'h7: p = 8'h07;
      4'h8: p = 8'h7F;
      4'h9: p = 8'h6F;
      4'hA: p = 8'h77;
      4'hB: p = 8'h7C;
      4'hC: p = 8'h39;
      4'hD: p = 8'h5E;
      4'hE: p = 8'h79;
      default: p = 8'h71;
    endcase
    return ~p;
  endfunction

  assign in_ready = (state_q == S_IDLE);
  assign segs_reg = segs_q;

  // add-3 correction on every BCD digit before the shift
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k <= NUM_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    hexv = HW'(data_q);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digs[k] = mode_q ? bcd_q[4*k +: 4] : hexv[4*k +: 4];
    end
    msd = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (digs[k] != 4'd0) msd = 5'(k);
    end
    err = mode_q & (ovf_q | (bcd_q[BW-1 -: 4] != 4'd0));
    for (int k = 0; k < NUM_DIGITS; k++) begin
      pat[k] = (!blz_q || 5'(k) <= msd) ? seg7(digs[k]) : SEG_NONE;
    end
`ifdef SEG_SIGNED_EN
    mpos = blz_q ? msd + 5'd1 : 5'(NUM_DIGITS - 1);
    if (mode_q && neg_q) begin
      if (msd < 5'(NUM_DIGITS - 1)) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (5'(k) == mpos) pat[k] = SEG_MINUS;
        end
      end else begin
        err = 1'b1;
      end
    end
`endif
    if (err) pat = {NUM_DIGITS{SEG_ERR}};
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    blz_d   = blz_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    bit_d   = bit_q;
    held_d  = held_q;
`ifdef SEG_SIGNED_EN
    neg_d   = neg_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          mode_d  = in_mode;
          blz_d   = blank_lz;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          bit_d   = '0;
          state_d = in_mode ? S_CONVERT : S_UPDATE;
`ifdef SEG_SIGNED_EN
          neg_d   = in_mode & in_data[DATA_WIDTH-1];
          if (neg_d) data_d = -in_data;
`endif
        end
      end
      S_CONVERT: begin
        // a carry out of the top digit is sticky overflow
        bcd_d  = {adj[BW-2:0], data_q[DATA_WIDTH-1]};
        ovf_d  = ovf_q | adj[BW-1];
        data_d = data_q << 1;
        bit_d  = bit_q + NW'(1);
        if (bit_q == NW'(DATA_WIDTH - 1)) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        held_d  = pat;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    phase_d = phase_q;
    if (cnt_q == CW'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      segs_d[k] = (!phase_q && blink_mask[k]) ? SEG_NONE : held_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      mode_q  <= 1'b0;
      blz_q   <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      bit_q   <= '0;
      held_q  <= {NUM_DIGITS{SEG_NONE}};
      segs_q  <= {NUM_DIGITS{SEG_NONE}};
      cnt_q   <= '0;
      phase_q <= 1'b1;
`ifdef SEG_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      blz_q   <= blz_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      bit_q   <= bit_d;
      held_q  <= held_d;
      segs_q  <= segs_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
`ifdef SEG_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: directed + random requests vs arithmetic model.
// Honours SEG_SIGNED_EN in the model when the macro is defined.
module tb_seg_display_ctrl;

  localparam logic [7:0] SEGT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_data = '0;
  logic            in_mode = 1'b0;
  logic            blank_lz = 1'b0;
  logic [7:0]      blink_mask = '0;
  logic [7:0][7:0] segs;

  int          tests = 0;
  int          fails = 0;
  int          ncnt = 0;
  logic [63:0] prev;

  seg_display_ctrl #(
    .NUM_DIGITS(8),
    .DATA_WIDTH(32),
    .BLINK_DIV (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .blank_lz  (blank_lz),
    .blink_mask(blink_mask),
    .segs_reg  (segs)
  );

  always #5 clk = ~clk;

  // clock edges seen since reset released
  always @(posedge clk or posedge rst) begin
    if (rst) ncnt <= 0;
    else     ncnt <= ncnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] model(input logic [31:0] v, input bit m,
                                        input bit b);
    logic [63:0]     r;
    longint unsigned mag, t;
    int              nd, d;
    bit              neg;
    r   = '0;
    neg = 1'b0;
    if (!m) begin
      nd = 1;
      for (int k = 0; k < 8; k++)
        if (((v >> (4 * k)) & 32'hF) != 0) nd = k + 1;
      for (int k = 0; k < 8; k++) begin
        d = int'((v >> (4 * k)) & 32'hF);
        r[8*k +: 8] = (b && k >= nd) ? 8'hFF : ~SEGT[d];
      end
      return r;
    end
    mag = {32'd0, v};
`ifdef SEG_SIGNED_EN
    if (v[31]) begin
      neg = 1'b1;
      mag = 64'h1_0000_0000 - {32'd0, v};
    end
`endif
    nd = 1;
    t  = mag;
    while (t >= 10) begin
      nd++;
      t = t / 10;
    end
    if (nd + int'(neg) > 8) return {8{8'hB6}};
    t = mag;
    for (int k = 0; k < 8; k++) begin
      d = int'(t % 10);
      t = t / 10;
      r[8*k +: 8] = (b && k >= nd) ? 8'hFF : ~SEGT[d];
    end
    if (neg) r[8*(b ? nd : 7) +: 8] = 8'hBF;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] v, input bit m, input bit b,
                      input string tag);
    logic [63:0] e;
    int          n;
    int          lat;
    e   = model(v, m, b);
    lat = m ? 34 : 2;
    n   = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_data  = v;
    in_mode  = m;
    blank_lz = b;
    @(posedge clk);
    #1;
    check({tag, "_busy"}, {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    // keep a bogus request pending while busy; it must be ignored
    in_valid = m;
    in_data  = ~v;
    in_mode  = ~m;
    blank_lz = ~b;
    for (int c = 1; c < lat; c++) begin
      @(posedge clk);
      if (c == lat - 2) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    #1;
    check({tag, "_early"}, segs, prev);
    @(posedge clk);
    #1;
    check({tag, "_val"}, segs, e);
    prev = e;
  endtask

  initial begin
    logic [31:0] v;
    logic [63:0] e;
    #2 rst = 1'b1;
    #1;
    check("rst_segs", segs, {8{8'hFF}});
    check("rst_rdy", {63'd0, in_ready}, 64'd1);
    prev = {8{8'hFF}};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    send(32'h1234ABCD, 1'b0, 1'b0, "hex_1234abcd");
    send(32'd12345, 1'b1, 1'b1, "dec_12345");
    send(32'd100000000, 1'b1, 1'b0, "dec_ovf9");
    send(32'd0, 1'b1, 1'b1, "dec_zero");
    send(32'hFFFFFFD6, 1'b1, 1'b1, "dec_m42");
    send(32'd99999999, 1'b1, 1'b0, "dec_max8");
    send(-32'sd9999999, 1'b1, 1'b0, "dec_m7dig");
    send(32'h0000_00F0, 1'b0, 1'b1, "hex_blank");
    send(32'd0, 1'b0, 1'b1, "hex_zero");

    for (int i = 0; i < 16; i++) begin
      unique case (i % 4)
        0: v = $urandom;
        1: v = $urandom_range(0, 99999999);
        2: v = $urandom_range(0, 9999);
        default: v = 32'hFFFFFFFF - $urandom_range(0, 500);
      endcase
      send(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
    end

    // reset in the middle of a decimal conversion
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'd987654;
    in_mode  = 1'b1;
    blank_lz = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_segs", segs, {8{8'hFF}});
    check("midrst_rdy", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    prev = {8{8'hFF}};
    send(32'h7, 1'b0, 1'b0, "hex_7");

    // blink on digit 0 only
    send(32'h5, 1'b0, 1'b0, "hex_5");
    @(negedge clk);
    blink_mask = 8'h01;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      e = prev;
      if (((ncnt - 1) / 4) % 2 == 1) e[7:0] = 8'hFF;
      check("blink", segs, e);
    end
    @(negedge clk);
    blink_mask = 8'h00;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
